// File: rtl/fmap_ser2par_pkg.sv
// fmap_ser2par_pkg: geometry and number-format defaults shared by the column
// assembler and the PE array it feeds.
// Ports: none (package of localparams only).
package fmap_ser2par_pkg;

  // Array geometry: pixels per column (array height) and columns per channel.
  localparam int unsigned HIT_DEF = 56;
  localparam int unsigned WID_DEF = 56;

  // Fixed-point pixel format. Only the total width matters here: pixels are
  // copied bit-exact and never interpreted by this block.
  localparam int unsigned IW_DEF  = 24;
  localparam int unsigned FW_DEF  = 8;
  localparam int unsigned DW_DEF  = IW_DEF + FW_DEF;

endpackage

// File: rtl/fmap_ser2par_bank.sv
// col_bank: one ping-pong half; HIT x DW pixel register file, a full flag and
// the channel column index of the column it holds.
// Ports: clk/rst; i_wr_en/i_wr_slot/i_wr_data pixel write; i_set_full/i_col_idx
// close a column; i_clr_full releases it; o_full/o_data/o_col_idx state out.
module col_bank
  import fmap_ser2par_pkg::*;
#(
  parameter int unsigned HIT = HIT_DEF,
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned SW  = (HIT > 1) ? $clog2(HIT) : 1,
  parameter int unsigned IXW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [SW-1:0]     i_wr_slot,
  input  logic [DW-1:0]     i_wr_data,
  input  logic              i_set_full,
  input  logic [IXW-1:0]    i_col_idx,
  input  logic              i_clr_full,
  output logic              o_full,
  output logic [HIT*DW-1:0] o_data,
  output logic [IXW-1:0]    o_col_idx
);

  logic [DW-1:0]  r_mem [HIT];
  logic           r_full;
  logic [IXW-1:0] r_col_idx;

  // Pixel storage. The top only writes while the bank is not full, so the
  // contents stay frozen for as long as the column waits for the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < HIT; r++) begin
        r_mem[r] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_slot] <= i_wr_data;
    end
  end

  // Set and clear never coincide: set only happens while empty, clear only
  // while full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= 1'b0;
      r_col_idx <= '0;
    end else if (i_set_full) begin
      r_full    <= 1'b1;
      r_col_idx <= i_col_idx;
    end else if (i_clr_full) begin
      r_full    <= 1'b0;
    end
  end

  for (genvar r = 0; r < HIT; r++) begin : g_pack
    assign o_data[r*DW +: DW] = r_mem[r];
  end

  assign o_full    = r_full;
  assign o_col_idx = r_col_idx;

endmodule

// File: rtl/fmap_ser2par.sv
// fmap_ser2par: packs a 1-pixel/cycle stream into HIT-pixel columns (row 0 at
// the LSBs) through two ping-pong banks; column valid one cycle after the last
// pixel. s_ready depends only on bank state, never combinationally on col_ready.
// Ports: clk/rst; s_data/s_valid/s_ready pixel stream in; col_o/col_valid/
// col_ready column out; col_idx/col_last position of col_o within its channel.
module fmap_ser2par
  import fmap_ser2par_pkg::*;
#(
  parameter int unsigned HIT = HIT_DEF,
  parameter int unsigned WID = WID_DEF,
  parameter int unsigned DW  = DW_DEF,
  localparam int unsigned SW  = (HIT > 1) ? $clog2(HIT) : 1,
  localparam int unsigned IXW = (WID > 1) ? $clog2(WID) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [HIT*DW-1:0] col_o,
  output logic              col_valid,
  input  logic              col_ready,
  output logic [IXW-1:0]    col_idx,
  output logic              col_last
);

  localparam logic [SW-1:0]  LAST_SLOT = SW'(HIT - 1);
  localparam logic [IXW-1:0] LAST_COL  = IXW'(WID - 1);

  logic           r_wr_bank;
  logic           r_rd_bank;
  logic [SW-1:0]  r_wr_cnt;
  logic [IXW-1:0] r_wr_col;

  logic              w_wr_fire;
  logic              w_col_done;
  logic              w_rd_fire;
  logic [1:0]        w_full;
  logic [1:0]        w_bank_wr;
  logic [1:0]        w_bank_set;
  logic [1:0]        w_bank_clr;
  logic [HIT*DW-1:0] w_data [2];
  logic [IXW-1:0]    w_idx  [2];

  assign s_ready    = !w_full[r_wr_bank];
  assign col_valid  = w_full[r_rd_bank];
  assign col_o      = w_data[r_rd_bank];
  assign col_idx    = w_idx[r_rd_bank];
  assign col_last   = col_valid && (col_idx == LAST_COL);

  assign w_wr_fire  = s_valid && s_ready;
  assign w_col_done = w_wr_fire && (r_wr_cnt == LAST_SLOT);
  assign w_rd_fire  = col_valid && col_ready;

  // Per-bank strobes. A fill completing on one bank and a drain of the other
  // in the same cycle both land, since the write side only targets a non-full
  // bank and the read side only a full one.
  assign w_bank_wr  = {w_wr_fire  &&  r_wr_bank, w_wr_fire  && !r_wr_bank};
  assign w_bank_set = {w_col_done &&  r_wr_bank, w_col_done && !r_wr_bank};
  assign w_bank_clr = {w_rd_fire  &&  r_rd_bank, w_rd_fire  && !r_rd_bank};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_wr_col  <= '0;
    end else begin
      if (w_wr_fire) begin
        r_wr_cnt <= w_col_done ? '0 : r_wr_cnt + SW'(1);
      end
      if (w_col_done) begin
        r_wr_bank <= !r_wr_bank;
        r_wr_col  <= (r_wr_col == LAST_COL) ? '0 : r_wr_col + IXW'(1);
      end
      if (w_rd_fire) begin
        r_rd_bank <= !r_rd_bank;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    col_bank #(
      .HIT (HIT),
      .DW  (DW),
      .SW  (SW),
      .IXW (IXW)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (w_bank_wr[b]),
      .i_wr_slot  (r_wr_cnt),
      .i_wr_data  (s_data),
      .i_set_full (w_bank_set[b]),
      .i_col_idx  (r_wr_col),
      .i_clr_full (w_bank_clr[b]),
      .o_full     (w_full[b]),
      .o_data     (w_data[b]),
      .o_col_idx  (w_idx[b])
    );
  end

endmodule

// File: tb/tb_fmap_ser2par.sv
// tb_fmap_ser2par: directed bench for the serial-to-parallel column assembler.
// Inputs are driven 1 time unit after each rising edge and outputs are sampled
// there too; all DUT outputs depend only on registered state.
module tb_fmap_ser2par;

  localparam int HIT = 56;
  localparam int WID = 56;
  localparam int DW  = 32;
  localparam logic [31:0] STEP = 32'h0001_0003;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     s_data;
  logic              s_valid;
  logic              s_ready;
  logic [HIT*DW-1:0] col_o;
  logic              col_valid;
  logic              col_ready;
  logic [5:0]        col_idx;
  logic              col_last;

  int n_checks = 0;
  int n_fail   = 0;

  fmap_ser2par #(.HIT(HIT), .WID(WID), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .col_o     (col_o),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .col_idx   (col_idx),
    .col_last  (col_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pixel k of a stream: base + k*STEP (STEP odd, so all values distinct).
  function automatic logic [31:0] pv(input logic [31:0] base, input int k);
    return base + 32'(k) * STEP;
  endfunction

  task automatic send_pixel(input logic [DW-1:0] d);
    int w;
    w = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && w < 300) begin
      tick();
      w++;
    end
    if (!s_ready) chk("send_timeout_s_ready", s_ready, 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic check_col(input string tag, input logic [31:0] first,
                           input logic [31:0] step, input int idx);
    logic [31:0] e;
    chk({tag, "_valid"}, col_valid, 1);
    chk({tag, "_idx"}, col_idx, idx);
    chk({tag, "_last"}, col_last, (idx == WID - 1));
    for (int r = 0; r < HIT; r++) begin
      e = first + 32'(r) * step;
      chk($sformatf("%s_pix%0d", tag, r), col_o[r*DW +: DW], e);
    end
  endtask

  task automatic check_colc(input string tag, input logic [31:0] base, input int c, input int idx);
    check_col(tag, pv(base, c * HIT), STEP, idx);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_col_valid"}, col_valid, 0);
    chk({tag, "_col_last"}, col_last, 0);
    chk({tag, "_col_idx"}, col_idx, 0);
    chk({tag, "_col_o_any"}, |col_o, 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    col_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_col(input logic [31:0] base, input int c, input int n);
    for (int r = 0; r < n; r++) send_pixel(pv(base, c * HIT + r));
  endtask

  initial begin : main
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    col_ready = 1'b0;
    repeat (2) tick();

    // Reset values, then a single column of pixels 0..55 with the array ready.
    do_reset();
    check_reset("rst");
    col_ready = 1'b1;
    for (int r = 0; r < HIT; r++) begin
      chk("t1_s_ready", s_ready, 1);
      chk("t1_valid_early", col_valid, 0);
      send_pixel(32'(r));
    end
    check_col("t1", 32'd0, 32'd1, 0);
    chk("t1_s_ready_end", s_ready, 1);
    tick();
    chk("t1_drained", col_valid, 0);
    col_ready = 1'b0;

    // Array stalled: two columns fill, pixel 112 is held, one drain frees a bank.
    do_reset();
    send_col(32'h1000_0000, 0, HIT);
    send_col(32'h1000_0000, 1, HIT);
    chk("t2_s_ready_full", s_ready, 0);
    check_colc("t2_c0", 32'h1000_0000, 0, 0);
    s_valid = 1'b1;
    s_data  = pv(32'h1000_0000, 2 * HIT);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_held_s_ready", s_ready, 0);
      chk("t2_held_idx", col_idx, 0);
    end
    col_ready = 1'b1;
    tick();
    col_ready = 1'b0;
    chk("t2_s_ready_back", s_ready, 1);
    check_colc("t2_c1", 32'h1000_0000, 1, 1);
    send_col(32'h1000_0000, 2, HIT);
    chk("t2_s_ready_full2", s_ready, 0);
    check_colc("t2_c1b", 32'h1000_0000, 1, 1);
    col_ready = 1'b1;
    tick();
    check_colc("t2_c2", 32'h1000_0000, 2, 2);
    tick();
    col_ready = 1'b0;
    chk("t2_empty", col_valid, 0);

    // Fill completes on B1 in the very cycle B0 drains.
    do_reset();
    send_col(32'h4000_0000, 0, HIT);
    send_col(32'h4000_0000, 1, HIT - 1);
    col_ready = 1'b1;
    send_pixel(pv(32'h4000_0000, 2 * HIT - 1));
    col_ready = 1'b0;
    check_colc("t4_c1", 32'h4000_0000, 1, 1);
    chk("t4_s_ready", s_ready, 1);

    // Column held for 20 cycles while the other bank fills: output frozen.
    for (int i = 0; i < 20; i++) begin
      send_pixel(pv(32'h4000_0000, 2 * HIT + i));
      check_colc("t6_stable", 32'h4000_0000, 1, 1);
    end

    // Reset with column 2 pending and column 3 partially written.
    do_reset();
    col_ready = 1'b1;
    send_col(32'h5000_0000, 0, HIT);
    send_col(32'h5000_0000, 1, HIT);
    tick();
    col_ready = 1'b0;
    chk("t5_idle", col_valid, 0);
    send_col(32'h5000_0000, 2, HIT);
    send_col(32'h5000_0000, 3, 30);
    check_colc("t5_c2", 32'h5000_0000, 2, 2);
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = pv(32'h5000_0000, 3 * HIT + 30);
    tick();
    check_reset("t5_rst");
    rst     = 1'b0;
    s_valid = 1'b0;
    for (int r = 0; r < HIT; r++) begin
      chk("t5_not_early", col_valid, 0);
      send_pixel(pv(32'h6000_0000, r));
    end
    check_colc("t5_after", 32'h6000_0000, 0, 0);

    // Full channel plus one column with random source gaps and random ready.
    do_reset();
    fork
      begin : sender
        int gap;
        for (int k = 0; k < (WID + 1) * HIT; k++) begin
          gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
          repeat (gap) tick();
          send_pixel(pv(32'h3000_0000, k));
        end
      end
      begin : receiver
        int n;
        int cyc;
        n   = 0;
        cyc = 0;
        while (n < WID + 1 && cyc < 30000) begin
          col_ready = ($urandom_range(0, 1) == 1);
          if (col_valid && col_ready) begin
            check_colc($sformatf("t3_c%0d", n), 32'h3000_0000, n, n % WID);
            n++;
          end else if (col_valid) begin
            chk("t3_last_vs_idx", col_last, (col_idx == 6'(WID - 1)));
          end
          tick();
          cyc++;
        end
        col_ready = 1'b0;
        chk("t3_cols", n, WID + 1);
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
